// File: rtl/cfg_serial_pkg.sv
// rtl/cfg_serial_pkg.sv - shared types and sizing for the serial config loader
//
// Purpose : FSM state type, default frame length and bit-counter width for
//           cfg_serial_loader and its shift-register sub-module.
// Ports   : none (package).
// Config  : CFG_SERIAL_PARITY_EN adds one trailing even-parity bit per frame.

package cfg_serial_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 12;

  // Payload bits per frame (address + data), excluding any parity bit.
  localparam int FRAME_LEN = DEF_ADDR_W + DEF_DATA_W;

`ifdef CFG_SERIAL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // The counter must reach required length + 1 so that a long frame stays
  // distinguishable from a correct one.
  localparam int CNT_W = $clog2(FRAME_LEN + PAR_BITS + 2);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int req_len);
    return $clog2(req_len + 2);
  endfunction

endpackage

// File: rtl/cfg_serial_shreg.sv
// rtl/cfg_serial_shreg.sv - frame shift register with saturating bit counter
//
// Purpose : Collects serial bits MSB first and counts them. The counter
//           saturates at WIDTH+1; the shift register freezes once WIDTH bits
//           are held so overlong frames cannot corrupt the captured prefix.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           i_load_first      - first bit of a new frame (restarts count at 1)
//           i_shift           - further frame bit
//           i_bit             - serial bit being sampled
//           o_shreg [WIDTH]   - collected bits, last received bit in [0]
//           o_cnt   [CNT_W]   - number of bits received (saturating)

import cfg_serial_pkg::*;

module cfg_serial_shreg #(
  parameter int WIDTH = FRAME_LEN,
  parameter int CNT_W = cfg_serial_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_first,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_shreg,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] L_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] L_SAT  = CNT_W'(WIDTH + 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_load_first) begin
      r_shreg <= {{(WIDTH-1){1'b0}}, i_bit};
      r_cnt   <= CNT_W'(1);
    end else if (i_shift) begin
      if (r_cnt < L_FULL) begin
        r_shreg <= {r_shreg[WIDTH-2:0], i_bit};
      end
      if (r_cnt != L_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_shreg = r_shreg;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/cfg_serial_loader.sv
// rtl/cfg_serial_loader.sv - serial frame to register-map write strobe
//
// Purpose : Receives {addr, data} frames on sdi while sen is high and, when
//           sen drops after exactly the required number of bits, issues a
//           one-cycle write strobe with the captured address and data.
//           Wrong-length (or, with parity, bad-parity) frames are dropped and
//           latch the sticky frame_err flag.
// Ports   : clk, rst   - clock, asynchronous active-high reset
//           sen, sdi   - frame enable and serial data (MSB first)
//           err_clr    - synchronous clear of frame_err (a coincident set wins)
//           valid      - one-cycle write strobe
//           addr, data - write address/data, held between writes
//           busy       - frame in progress
//           frame_err  - sticky dropped-frame flag
//           wr_cnt     - accepted-write counter, wraps at 256
// Config  : CFG_SERIAL_PARITY_EN - frame carries a trailing even-parity bit.

import cfg_serial_pkg::*;

module cfg_serial_loader #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sdi,
  input  logic              err_clr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        wr_cnt
);

  localparam int L_FRAME_LEN = ADDR_W + DATA_W;
  localparam int L_REQ_LEN   = L_FRAME_LEN + PAR_BITS;
  localparam int L_CNT_W     = cnt_width(L_REQ_LEN);

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_load_first;
  logic                 w_shift;
  logic                 w_close;
  logic                 w_len_ok;
  logic                 w_par_ok;
  logic                 w_accept;
  logic                 w_drop;
  logic [L_REQ_LEN-1:0] w_shreg;
  logic [L_CNT_W-1:0]   w_cnt;

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_frame_err;
  logic [7:0]        r_wr_cnt;

  cfg_serial_shreg #(
    .WIDTH (L_REQ_LEN),
    .CNT_W (L_CNT_W)
  ) u_shreg (
    .clk          (clk),
    .rst          (rst),
    .i_load_first (w_load_first),
    .i_shift      (w_shift),
    .i_bit        (sdi),
    .o_shreg      (w_shreg),
    .o_cnt        (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_first = 1'b0;
    w_shift      = 1'b0;
    w_close      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sen) begin
          w_load_first = 1'b1;
          w_state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sen) begin
          w_shift = 1'b1;
        end else begin
          w_close     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_len_ok = (w_cnt == L_CNT_W'(L_REQ_LEN));

`ifdef CFG_SERIAL_PARITY_EN
  // Even parity: XOR over payload plus parity bit must be zero.
  assign w_par_ok = ~(^w_shreg);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_accept = w_close & w_len_ok & w_par_ok;
  assign w_drop   = w_close & ~w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
      r_wr_cnt    <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        // Address occupies the oldest bits; any parity bit sits below data.
        r_addr   <= w_shreg[L_REQ_LEN-1 -: ADDR_W];
        r_data   <= w_shreg[PAR_BITS +: DATA_W];
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end
      if (w_drop) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign valid     = r_valid;
  assign addr      = r_addr;
  assign data      = r_data;
  assign busy      = (r_state == ST_SHIFT);
  assign frame_err = r_frame_err;
  assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_cfg_serial_loader.sv
// tb/tb_cfg_serial_loader.sv - self-checking bench for cfg_serial_loader

module tb_cfg_serial_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 12;
  localparam int FLEN   = ADDR_W + DATA_W;
`ifdef CFG_SERIAL_PARITY_EN
  localparam int REQ    = FLEN + 1;
`else
  localparam int REQ    = FLEN;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              sen;
  logic              sdi;
  logic              err_clr;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              frame_err;
  logic [7:0]        wr_cnt;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         valid_cycles = 0;
  logic [7:0] exp_wr = 8'd0;
  exp_t       sb_q[$];

  cfg_serial_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sen       (sen),
    .sdi       (sdi),
    .err_clr   (err_clr),
    .valid     (valid),
    .addr      (addr),
    .data      (data),
    .busy      (busy),
    .frame_err (frame_err),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid === 1'b1) begin
      valid_cycles++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_valid: got addr=%0h data=%0h, required no write", addr, data);
      end else begin
        e = sb_q.pop_front();
        if (addr !== e.a || data !== e.d) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   addr, data, e.a, e.d);
        end
      end
    end
  end

  function automatic logic [63:0] mk_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [63:0] f;
    f = 64'({a, d});
`ifdef CFG_SERIAL_PARITY_EN
    f = {f[62:0], ^{a, d}};
`endif
    return f;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = bits[i];
    end
    @(negedge clk);
    sen = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic send_good(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    sb_q.push_back('{a: a, d: d});
    exp_wr = exp_wr + 8'd1;
    send_bits(mk_frame(a, d), REQ);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sen = 1'b0; sdi = 1'b0; err_clr = 1'b0;
    wait_cyc(3);
    n_tests++;
    if ({valid, busy, frame_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/busy/err=%b, required 000", {valid, busy, frame_err});
    end
    n_tests++;
    if (addr !== '0 || data !== '0 || wr_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got addr=%0h data=%0h wr_cnt=%0d, required 0 0 0", addr, data, wr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int vc0;
    vc0 = valid_cycles;
    send_good(6'd3, 12'h155);
    wait_cyc(3);
    n_tests++;
    if (valid_cycles - vc0 !== 1) begin
      n_fail++;
      $display("FAIL single_pulse_len: got %0d valid cycles, required 1", valid_cycles - vc0);
    end
    n_tests++;
    if (wr_cnt !== exp_wr || addr !== 6'd3 || data !== 12'h155) begin
      n_fail++;
      $display("FAIL single_hold: got wr_cnt=%0d addr=%0h data=%0h, required %0d 3 155",
               wr_cnt, addr, data, exp_wr);
    end
  endtask

  task automatic test_short();
    int vc0;
    vc0 = valid_cycles;
    send_bits(mk_frame(6'h2A, 12'h0F0) >> 1, REQ - 1);
    wait_cyc(3);
    n_tests++;
    if (valid_cycles !== vc0 || frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_drop: got valid_cycles+%0d frame_err=%b, required +0 1",
               valid_cycles - vc0, frame_err);
    end
    n_tests++;
    if (addr !== 6'd3 || data !== 12'h155) begin
      n_fail++;
      $display("FAIL short_hold: got addr=%0h data=%0h, required 3 155", addr, data);
    end
    pulse_err_clr();
    n_tests++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: got frame_err=%b, required 0", frame_err);
    end
  endtask

  task automatic test_long();
    int vc0;
    vc0 = valid_cycles;
    send_bits({mk_frame(6'h11, 12'h222), 1'b0}, REQ + 1);
    wait_cyc(3);
    n_tests++;
    if (valid_cycles !== vc0 || frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL long_drop: got valid_cycles+%0d frame_err=%b, required +0 1",
               valid_cycles - vc0, frame_err);
    end
    pulse_err_clr();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = 1'($urandom_range(0, 1));
    end
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold40_busy: got busy=%b, required 1", busy);
    end
    @(negedge clk);
    sen = 1'b0;
    wait_cyc(3);
    n_tests++;
    if (valid_cycles !== vc0 || frame_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold40_drop: got valid_cycles+%0d frame_err=%b busy=%b, required +0 1 0",
               valid_cycles - vc0, frame_err, busy);
    end
  endtask

  task automatic test_err_set_wins();
    pulse_err_clr();
    send_bits(mk_frame(6'h01, 12'h001) >> 2, REQ - 2);
    // Hold err_clr across the edge that closes the short frame.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    wait_cyc(1);
    n_tests++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_wins: got frame_err=%b, required 1", frame_err);
    end
    pulse_err_clr();
  endtask

  task automatic test_back_to_back();
    int vc0;
    vc0 = valid_cycles;
    send_good(6'd6, 12'hFFF);
    send_good(6'd13, 12'h001);
    wait_cyc(3);
    n_tests++;
    if (valid_cycles - vc0 !== 2 || sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d valid cycles, %0d pending, required 2 0",
               valid_cycles - vc0, sb_q.size());
    end
    n_tests++;
    if (wr_cnt !== exp_wr || addr !== 6'd13 || data !== 12'h001) begin
      n_fail++;
      $display("FAIL b2b_hold: got wr_cnt=%0d addr=%0h data=%0h, required %0d d 1",
               wr_cnt, addr, data, exp_wr);
    end
  endtask

  task automatic test_mid_reset();
    int vc0;
    logic [63:0] f;
    f = mk_frame(6'h3F, 12'hA5A);
    for (int i = REQ - 1; i > REQ - 10; i--) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = f[i];
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({valid, busy, frame_err} !== 3'b000 || addr !== '0 || data !== '0 || wr_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got v/b/e=%b addr=%0h data=%0h wr_cnt=%0d, required all 0",
               {valid, busy, frame_err}, addr, data, wr_cnt);
    end
    sen = 1'b0;
    sdi = 1'b0;
    exp_wr = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    vc0 = valid_cycles;
    wait_cyc(3);
    n_tests++;
    if (frame_err !== 1'b0 || valid_cycles !== vc0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got frame_err=%b valid_cycles+%0d, required 0 +0",
               frame_err, valid_cycles - vc0);
    end
    send_good(6'd0, 12'h001);
    wait_cyc(3);
    n_tests++;
    if (data !== 12'h001 || wr_cnt !== exp_wr || valid_cycles - vc0 !== 1) begin
      n_fail++;
      $display("FAIL post_reset_frame: got data=%0h wr_cnt=%0d writes=%0d, required 1 %0d 1",
               data, wr_cnt, valid_cycles - vc0, exp_wr);
    end
  endtask

  task automatic test_sen_at_release();
    logic [63:0] f;
    f = mk_frame(6'h2A, 12'hABC);
    @(negedge clk);
    rst = 1'b1;
    sen = 1'b1;
    sdi = f[REQ-1];
    @(negedge clk);
    rst = 1'b0;
    exp_wr = 8'd1;
    sb_q.push_back('{a: 6'h2A, d: 12'hABC});
    for (int i = REQ - 2; i >= 0; i--) begin
      @(negedge clk);
      sdi = f[i];
    end
    @(negedge clk);
    sen = 1'b0;
    sdi = 1'b0;
    wait_cyc(3);
    n_tests++;
    if (wr_cnt !== exp_wr || addr !== 6'h2A || data !== 12'hABC || sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sen_at_release: got wr_cnt=%0d addr=%0h data=%0h pending=%0d, required 1 2a abc 0",
               wr_cnt, addr, data, sb_q.size());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 255; i++) begin
      send_good(6'($urandom), 12'($urandom));
    end
    wait_cyc(3);
    n_tests++;
    if (wr_cnt !== exp_wr || wr_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wr_cnt_wrap: got %0d, required 0 (model %0d)", wr_cnt, exp_wr);
    end
    send_good(6'h15, 12'h3C3);
    wait_cyc(3);
    n_tests++;
    if (wr_cnt !== 8'd1 || sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL wr_cnt_after_wrap: got %0d pending=%0d, required 1 0", wr_cnt, sb_q.size());
    end
  endtask

`ifdef CFG_SERIAL_PARITY_EN
  task automatic test_parity();
    int vc0;
    logic [63:0] f;
    vc0 = valid_cycles;
    pulse_err_clr();
    f = mk_frame(6'h09, 12'h123);
    f[0] = ~f[0];
    send_bits(f, REQ);
    wait_cyc(3);
    n_tests++;
    if (valid_cycles !== vc0 || frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_drop: got valid_cycles+%0d frame_err=%b, required +0 1",
               valid_cycles - vc0, frame_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_short();
    test_long();
    test_err_set_wins();
    test_back_to_back();
    test_mid_reset();
    test_sen_at_release();
    test_wrap();
`ifdef CFG_SERIAL_PARITY_EN
    test_parity();
`endif
    wait_cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
